// File: rtl/sha256_sequencer.sv
// rtl/sha256_sequencer.sv - sequences 512-bit blocks through the SHA-256 compressor and hasher
module sha256_sequencer #(
  parameter int ROUNDS  = 64,
  parameter int ROUND_W = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               blk_valid,
  input  logic               blk_first,
  input  logic               blk_last,
  output logic               blk_ready,
  output logic               sched_load,
  output logic               hash_wen,
  output logic               hash_init,
  output logic               comp_load,
  output logic               comp_en,
  output logic [ROUND_W-1:0] round_idx,
  output logic               busy,
  output logic               digest_valid,
  input  logic               digest_ack,
  output logic               err
);

  typedef enum logic [2:0] {IDLE, INIT, LOAD, ROUND, UPDATE, DONE} state_t;

  localparam logic [ROUND_W-1:0] LAST_ROUND = ROUND_W'(ROUNDS - 1);

  state_t state, state_nxt;
  logic   chain_open;
  logic   last_q;

  always_comb begin
    state_nxt    = state;
    blk_ready    = 1'b0;
    hash_wen     = 1'b0;
    hash_init    = 1'b0;
    comp_load    = 1'b0;
    comp_en      = 1'b0;
    busy         = 1'b1;
    digest_valid = 1'b0;
    case (state)
      IDLE: begin
        blk_ready = 1'b1;
        busy      = 1'b0;
        // A continuation block with no open message still gets INIT so the hasher is sane.
        if (blk_valid)
          state_nxt = (blk_first || !chain_open) ? INIT : LOAD;
      end
      INIT: begin
        hash_wen  = 1'b1;
        hash_init = 1'b1;
        state_nxt = LOAD;
      end
      LOAD: begin
        comp_load = 1'b1;
        state_nxt = ROUND;
      end
      ROUND: begin
        comp_en = 1'b1;
        if (round_idx == LAST_ROUND)
          state_nxt = UPDATE;
      end
      UPDATE: begin
        hash_wen  = 1'b1;
        state_nxt = last_q ? DONE : IDLE;
      end
      DONE: begin
        busy         = 1'b0;
        digest_valid = 1'b1;
        if (digest_ack)
          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign sched_load = blk_valid & blk_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      round_idx  <= '0;
      err        <= 1'b0;
      chain_open <= 1'b0;
      last_q     <= 1'b0;
    end else begin
      state <= state_nxt;
      if (sched_load) begin
        last_q <= blk_last;
        if (!blk_first && !chain_open)
          err <= 1'b1;
      end
      if (state == INIT)
        chain_open <= 1'b1;
      else if (state == DONE && digest_ack)
        chain_open <= 1'b0;
      // Counter returns to zero on the final round rather than relying on overflow.
      if (state == ROUND && round_idx != LAST_ROUND)
        round_idx <= round_idx + 1'b1;
      else
        round_idx <= '0;
    end
  end

endmodule

// File: doc/sha256_sequencer.md
Name: sha256_sequencer

Overview:
FSM controller that sequences one 512-bit message block at a time through the SHA-256 compressor and the hasher intermediate-hash registers. It accepts blocks over a valid/ready handshake and initialises the hasher on the first block of a message. It then loads the compressor working variables, steps the round counter, and commits the compressed result into the hasher. It raises digest_valid after the last block of a message.

Parameters:
ROUNDS, 64, compression rounds per block (must be >= 2 and <= 2**ROUND_W)
ROUND_W, 6, width of round_idx

Ports:
clk  in  1  rising-edge clock
rst  in  1  asynchronous, active-high reset
blk_valid  in  1  message block (schedule inputs) valid
blk_first  in  1  block is first of a message; sampled with handshake
blk_last  in  1  block is last of a message; sampled with handshake
blk_ready  out  1  sequencer can accept a block
sched_load  out  1  load message schedule from block (= blk_valid & blk_ready)
hash_wen  out  1  hasher write enable
hash_init  out  1  hasher loads IVs (qualified by hash_wen)
comp_load  out  1  compressor loads A..H from hash0..hash7
comp_en  out  1  compressor executes round round_idx
round_idx  out  ROUND_W  current round index (K/W select)
busy  out  1  high in any state except IDLE and DONE
digest_valid  out  1  hash0..hash7 hold final digest
digest_ack  in  1  consumer accepted digest
err  out  1  sticky: non-first block arrived with no open message

Behaviour:
- States: IDLE, INIT, LOAD, ROUND, UPDATE, DONE. All outputs are Moore-decoded from registered state except sched_load.
- Reset (async, any time including mid-round):
  - state=IDLE, round_idx=0, err=0, chain_open=0, first_q=0, last_q=0.
  - All strobes are 0. blk_ready=1 after reset deasserts.
  - The hasher has no reset, so hash contents are undefined until the next INIT.
- IDLE:
  - blk_ready=1.
  - On blk_valid=1, capture first_q/last_q and pulse sched_load in the same cycle.
  - Next state is INIT if blk_first=1 or chain_open=0; otherwise LOAD.
  - If blk_first=0 and chain_open=0, set err and still run INIT (recovery).
- INIT: hash_wen=1, hash_init=1 for exactly 1 cycle; set chain_open; next LOAD.
- LOAD: comp_load=1 for 1 cycle; round_idx=0; next ROUND.
- ROUND:
  - comp_en=1 every cycle; round_idx increments 0..ROUNDS-1, one per cycle.
  - On round_idx==ROUNDS-1, next UPDATE.
  - round_idx returns to 0 on leaving ROUND; it wraps by reset-to-0, never by overflow.
- UPDATE:
  - hash_wen=1, hash_init=0 for 1 cycle (hasher adds A..H).
  - If last_q, next DONE; else next IDLE.
- DONE:
  - digest_valid=1, blk_ready=0.
  - Held until digest_ack=1, then next IDLE and chain_open cleared.
  - digest_ack outside DONE is ignored.
- Handshake and latency:
  - blk_ready is high only in IDLE. blk_valid in other states is ignored and no block is consumed.
  - First block accepted at cycle 0: INIT @1, LOAD @2, rounds @3..ROUNDS+2, UPDATE @ROUNDS+3, then DONE or IDLE @ROUNDS+4.
  - Non-first block: LOAD @1, UPDATE @ROUNDS+2, IDLE/DONE @ROUNDS+3.
  - Block throughput is ROUNDS+3 cycles.
- blk_first=1 with chain_open=1 restarts the message (INIT) with no error.
- blk_first=1 and blk_last=1 together means a single-block message.
- hash_wen, comp_load, comp_en and sched_load are never asserted in the same cycle as one another.
- Only one of INIT/LOAD/ROUND/UPDATE is active per cycle.

Test Plan:
- Reset, then blk_valid=1, first=1, last=1 at cycle 0:
  - sched_load@0, hash_wen&hash_init@1, comp_load@2.
  - comp_en@3..66 with round_idx 0..63, hash_wen&!hash_init@67, digest_valid@68 held.
  - digest_ack@72 gives blk_ready=1@73.
- Integrated with compressor and hasher, the single padded block "abc" gives hash0..hash7 = ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad at digest_valid.
- Two-block message (first, then last):
  - The second block has no INIT, and LOAD follows acceptance by 1 cycle.
  - With "abcdbcdecdef...nopq" the digest is 248d6a61 d20638b8 e5c02693 0c3e6039 a33ce459 64ff2167 f6ecedd4 19db06c1.
- After reset, send blk_first=0: err=1 and stays 1, INIT is still inserted, and the sequence completes normally.
- Assert rst during ROUND at round_idx=30: state IDLE, round_idx=0, all strobes 0 immediately (asynchronous), err=0.
- blk_valid held high through ROUND and DONE: no extra sched_load, and the next block is accepted only in IDLE.
- digest_ack pulsed outside DONE: no effect.
